// File: rtl/hazard_flush_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_flush_ctrl
//
// Central hazard / flush controller for the 5-stage pipeline. Decides, every
// cycle, whether the front end stalls, which pipeline registers are zeroed,
// whether a taken branch is being resolved, and whether the instruction in ID
// is replaced by an interrupt trap. A three-state machine (RUN / STALL / ISR)
// tracks the single-cycle load-use stall and interrupt service.
//
// Ports
//   clk           clock, all state on rising edge
//   reset         asynchronous, active-low
//   irq_n         external interrupt request, active-low, asynchronous
//   irq_en        global interrupt enable
//   id_rs, id_rt  ID source register addresses
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   id_jump       ID holds J/JAL/JR/JALR
//   id_eret       ID holds return-from-interrupt
//   ex_mem_read   EX holds a load
//   ex_rt         load destination register in EX
//   ex_is_branch  EX holds a conditional branch
//   ex_cond_true  EX branch condition is true
//   pc_write      PC update enable
//   if_id_write   IF/ID write enable
//   if_id_flush   zero IF/ID
//   ex_flush      zero ID/EX (bubble)
//   ex_branch_en  taken branch in EX (combinational)
//   mem_branch_en ex_branch_en delayed one cycle
//   irq_tag       ID instruction replaced by interrupt trap (ID/EX ctr_in[0])
//   in_isr        interrupt service in progress
// ---------------------------------------------------------------------------
module hazard_flush_ctrl #(
   parameter int REG_AW   = 5,
   parameter int IRQ_SYNC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              irq_n,
   input  logic              irq_en,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_jump,
   input  logic              id_eret,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              ex_is_branch,
   input  logic              ex_cond_true,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              ex_flush,
   output logic              ex_branch_en,
   output logic              mem_branch_en,
   output logic              irq_tag,
   output logic              in_isr
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_ISR   = 2'd2;

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [IRQ_SYNC-1:0] irq_sync;
   logic                irq_req;
   logic                hazard;
   logic                load_use;
   logic                irq_accept;

   // ------------------------------------------------------------------------
   // Interrupt synchroniser: request is the inverted pin, level-sensitive,
   // taken from the last stage. Nothing is latched beyond the flop chain.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_sync <= '0;
      end else begin
         irq_sync <= {irq_sync[IRQ_SYNC-2:0], ~irq_n};
      end
   end

   assign irq_req = irq_sync[IRQ_SYNC-1];

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   assign ex_branch_en = ex_is_branch & ex_cond_true;

   // Register 0 is hard-wired zero, so a load into it never creates a hazard.
   assign hazard = ex_mem_read && (ex_rt != '0) &&
                   ((id_use_rs && (id_rs == ex_rt)) ||
                    (id_use_rt && (id_rt == ex_rt)));

   // The cycle after a stall the EX stage holds the bubble, so any hazard
   // seen in STALL is stale and must not stall again.
   assign load_use = hazard && (state != ST_STALL);

   assign irq_accept = irq_req && irq_en && !in_isr && !id_jump &&
                       (state == ST_RUN);

   // ------------------------------------------------------------------------
   // Prioritised control: branch > load-use > irq accept > jump
   // ------------------------------------------------------------------------
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      ex_flush    = 1'b0;
      irq_tag     = 1'b0;
      state_nxt   = state;

      if (ex_branch_en) begin
         if_id_flush = 1'b1;
         ex_flush    = 1'b1;
         // Branch resolution ends a stall but does not leave ISR, even with
         // an eret in ID (that eret is on the wrong path and gets flushed).
         if (state == ST_STALL) begin
            state_nxt = ST_RUN;
         end
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         ex_flush    = 1'b1;
         // Inside ISR the bubble is inserted without a STALL substate; a
         // stalled eret is simply presented again next cycle.
         if (state == ST_RUN) begin
            state_nxt = ST_STALL;
         end
      end else if (irq_accept) begin
         irq_tag   = 1'b1;
         state_nxt = ST_ISR;
      end else begin
         if_id_flush = id_jump;
         case (state)
            ST_STALL: state_nxt = ST_RUN;
            ST_ISR:   if (id_eret) state_nxt = ST_RUN;
            default:  state_nxt = state;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State and delayed branch enable
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_RUN;
         mem_branch_en <= 1'b0;
      end else begin
         state         <= state_nxt;
         mem_branch_en <= ex_branch_en;
      end
   end

   assign in_isr = (state == ST_ISR);

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_flush_ctrl
//
// Directed scoreboard bench. Each step drives inputs on the falling edge,
// pushes the hand-derived expected output vector, and pops/compares it once
// the combinational outputs have settled.
// Vector order: {pc_write, if_id_write, if_id_flush, ex_flush,
//                ex_branch_en, mem_branch_en, irq_tag, in_isr}
// ---------------------------------------------------------------------------
module tb_hazard_flush_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       irq_n;
   logic       irq_en;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic       id_jump;
   logic       id_eret;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       ex_is_branch;
   logic       ex_cond_true;
   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       ex_flush;
   logic       ex_branch_en;
   logic       mem_branch_en;
   logic       irq_tag;
   logic       in_isr;

   logic [7:0] obs;
   logic [7:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   hazard_flush_ctrl #(
      .REG_AW  (5),
      .IRQ_SYNC(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .irq_n        (irq_n),
      .irq_en       (irq_en),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_jump      (id_jump),
      .id_eret      (id_eret),
      .ex_mem_read  (ex_mem_read),
      .ex_rt        (ex_rt),
      .ex_is_branch (ex_is_branch),
      .ex_cond_true (ex_cond_true),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .if_id_flush  (if_id_flush),
      .ex_flush     (ex_flush),
      .ex_branch_en (ex_branch_en),
      .mem_branch_en(mem_branch_en),
      .irq_tag      (irq_tag),
      .in_isr       (in_isr)
   );

   assign obs = {pc_write, if_id_write, if_id_flush, ex_flush,
                 ex_branch_en, mem_branch_en, irq_tag, in_isr};

   task automatic check_val(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic sample(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, obs, e);
      end
   endtask

   // Called right after a falling edge with inputs already set.
   task automatic cyc(input string tag, input logic [7:0] exp);
      exp_q.push_back(exp);
      #1;
      sample(tag);
      @(negedge clk);
   endtask

   task automatic quiet();
      irq_n        = 1'b1;
      irq_en       = 1'b1;
      id_rs        = '0;
      id_rt        = '0;
      id_use_rs    = 1'b0;
      id_use_rt    = 1'b0;
      id_jump      = 1'b0;
      id_eret      = 1'b0;
      ex_mem_read  = 1'b0;
      ex_rt        = '0;
      ex_is_branch = 1'b0;
      ex_cond_true = 1'b0;
   endtask

   task automatic set_lu_rs(input logic [4:0] r);
      ex_mem_read = 1'b1;
      ex_rt       = r;
      id_rs       = r;
      id_use_rs   = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      quiet();
      @(negedge clk);
      cyc("reset_state", 8'b1100_0000);
      reset = 1'b1;

      // basic run
      cyc("idle", 8'b1100_0000);

      // load-use on rs: one bubble, then back to normal
      set_lu_rs(5'd5);
      cyc("lu_rs", 8'b0001_0000);
      cyc("lu_in_stall", 8'b1100_0000);
      quiet();
      cyc("lu_after", 8'b1100_0000);

      // load into r0 never stalls
      set_lu_rs(5'd0);
      cyc("lu_r0", 8'b1100_0000);

      // load-use on rt
      quiet();
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
      cyc("lu_rt", 8'b0001_0000);
      quiet();
      cyc("lu_rt_stall", 8'b1100_0000);

      // matching register but not read
      ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_use_rs = 1'b0;
      cyc("lu_unused", 8'b1100_0000);
      quiet();

      // taken branch, then delayed enable
      ex_is_branch = 1'b1; ex_cond_true = 1'b1;
      cyc("br_taken", 8'b1111_1000);
      quiet();
      cyc("br_mem", 8'b1100_0100);
      cyc("br_mem_clr", 8'b1100_0000);

      // branch not taken
      ex_is_branch = 1'b1;
      cyc("br_not_taken", 8'b1100_0000);
      quiet();

      // branch beats load-use, no STALL entered (next load-use still stalls)
      ex_is_branch = 1'b1; ex_cond_true = 1'b1; set_lu_rs(5'd5);
      cyc("br_vs_lu", 8'b1111_1000);
      quiet();
      cyc("br_vs_lu_mem", 8'b1100_0100);
      set_lu_rs(5'd5);
      cyc("br_vs_lu_run", 8'b0001_0000);
      quiet();
      cyc("br_vs_lu_stall", 8'b1100_0000);

      // jump
      id_jump = 1'b1;
      cyc("jump", 8'b1110_0000);
      quiet();

      // interrupt: tag two cycles after irq_n falls
      irq_n = 1'b0;
      cyc("irq_s0", 8'b1100_0000);
      cyc("irq_s1", 8'b1100_0000);
      cyc("irq_tag", 8'b1100_0010);
      cyc("isr_hold", 8'b1100_0001);
      cyc("isr_hold2", 8'b1100_0001);

      // load-use in ISR: no STALL substate, so a held hazard stalls again
      set_lu_rs(5'd5);
      cyc("isr_lu", 8'b0001_0001);
      cyc("isr_lu2", 8'b0001_0001);
      quiet(); irq_n = 1'b0;
      cyc("isr_lu_end", 8'b1100_0001);

      // eret together with taken branch stays in ISR
      id_eret = 1'b1; ex_is_branch = 1'b1; ex_cond_true = 1'b1;
      cyc("eret_br", 8'b1111_1001);
      quiet(); irq_n = 1'b0;
      cyc("isr_mb", 8'b1100_0101);
      id_eret = 1'b1;
      cyc("eret", 8'b1100_0001);
      id_eret = 1'b0;
      cyc("irq_tag2", 8'b1100_0010);
      cyc("isr3", 8'b1100_0001);
      id_eret = 1'b1; irq_n = 1'b1;
      cyc("eret2", 8'b1100_0001);
      id_eret = 1'b0; irq_en = 1'b0;
      cyc("irq_masked", 8'b1100_0000);
      irq_en = 1'b1;
      cyc("irq_gone", 8'b1100_0000);

      // deferral behind a 3-cycle jump
      irq_n = 1'b0; id_jump = 1'b1;
      cyc("defer_j1", 8'b1110_0000);
      cyc("defer_j2", 8'b1110_0000);
      cyc("defer_j3", 8'b1110_0000);
      id_jump = 1'b0;
      cyc("defer_tag", 8'b1100_0010);
      cyc("isr4", 8'b1100_0001);
      ex_is_branch = 1'b1; ex_cond_true = 1'b1;
      cyc("isr_br", 8'b1111_1001);

      // async reset between edges while in ISR with mem_branch_en high
      quiet(); irq_n = 1'b0;
      exp_q.push_back(8'b1100_0101);
      #1;
      sample("pre_async_rst");
      #1;
      reset = 1'b0;
      #1;
      exp_q.push_back(8'b1100_0000);
      sample("async_rst");
      @(negedge clk);
      reset = 1'b1; irq_n = 1'b1;
      cyc("post_rst", 8'b1100_0000);
      set_lu_rs(5'd9);
      cyc("post_rst_lu", 8'b0001_0000);
      quiet();
      cyc("post_rst_stall", 8'b1100_0000);
      cyc("post_rst_idle", 8'b1100_0000);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Central pipeline hazard and flush controller for the 5-stage pipelined CPU.
- Produces the stall, flush, branch-enable and interrupt-tag signals that the IF/ID and ID/EX pipeline registers consume:
  - ex_flush, ex_branch_en, mem_branch_en, irq_tag (driven into ID/EX ctr_in[0]).
- Resolves load-use hazards, taken branches in EX, jumps in ID, and external interrupt acceptance, with a small state machine for stall and ISR tracking.

Parameters:
- REG_AW, 5, register address width.
- IRQ_SYNC, 2, number of flip-flop stages synchronising irq_n (minimum 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- irq_n  in  1  external interrupt request, active-low, asynchronous to clk.
- irq_en  in  1  global interrupt enable (PC[31]==0 supervisor bit, decoded outside).
- id_rs  in  REG_AW  ID source register 1.
- id_rt  in  REG_AW  ID source register 2.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_jump  in  1  ID holds J/JAL/JR/JALR.
- id_eret  in  1  ID holds return-from-interrupt.
- ex_mem_read  in  1  EX holds a load.
- ex_rt  in  REG_AW  load destination in EX.
- ex_is_branch  in  1  EX holds a conditional branch.
- ex_cond_true  in  1  EX branch condition evaluates true.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register write enable.
- if_id_flush  out  1  zero the IF/ID register.
- ex_flush  out  1  zero the ID/EX register (bubble).
- ex_branch_en  out  1  taken branch currently in EX.
- mem_branch_en  out  1  ex_branch_en delayed one cycle.
- irq_tag  out  1  ID instruction is replaced by interrupt trap.
- in_isr  out  1  interrupt service in progress.

Behaviour:
- Reset (async, reset==0):
  - State RUN; synchroniser cleared to "no request".
  - mem_branch_en=0, in_isr=0.
  - Combinational outputs evaluate with state RUN: pc_write=1, if_id_write=1, all flushes and tags follow their inputs.
- irq_req: irq_n is inverted and passed through IRQ_SYNC flops. irq_req is the last stage; it is level-sensitive with no edge detect.
- ex_branch_en = ex_is_branch & ex_cond_true. Purely combinational, zero latency.
- mem_branch_en: registered ex_branch_en, latency 1.
- load_use = ex_mem_read & ex_rt!=0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
- Priority per cycle, highest first:
  1. ex_branch_en: if_id_flush=1, ex_flush=1, pc_write=1, if_id_write=1; no stall, no irq acceptance this cycle.
  2. load_use: pc_write=0, if_id_write=0, ex_flush=1; state RUN->STALL.
  3. Irq accept: requires irq_req & irq_en & !in_isr & !id_jump & state==RUN. Then irq_tag=1 for exactly this cycle and state RUN->ISR.
  4. id_jump, without a higher-priority event: if_id_flush=1 only.
- States:
  - RUN: normal operation; transitions as listed above.
  - STALL: lasts exactly 1 cycle. Outputs as RUN with load_use forced 0. Next state RUN. A taken branch in STALL still flushes (priority 1).
  - ISR: in_isr=1; no irq accepted. A further load_use here sets pc_write=0, if_id_write=0 and ex_flush=1 for 1 cycle, but the state stays ISR with no STALL substate; the hazard clears naturally once the bubble advances. id_eret & !ex_branch_en -> RUN next cycle.
- Irq deferral:
  - If irq_req is asserted while id_jump=1 or in STALL, acceptance waits for the first eligible RUN cycle.
  - irq_req deasserting before acceptance drops the request; nothing is latched.
- Simultaneous irq_tag and load_use: not possible, because load_use wins.
- ex_rt==0 never causes a stall.
- Reset mid-stall or mid-ISR returns to RUN immediately with in_isr=0.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_use_rs=1 -> pc_write=0, if_id_write=0, ex_flush=1 for exactly 1 cycle, then all back to 1/1/0.
- Taken branch: ex_is_branch=1, ex_cond_true=1 -> same cycle ex_branch_en=1, if_id_flush=1, ex_flush=1; next cycle mem_branch_en=1, then 0.
- Branch vs load-use: both conditions true in the same cycle -> pc_write=1, if_id_write=1, ex_flush=1, if_id_flush=1; no STALL entry.
- Irq sync and accept: irq_n driven 0 with irq_en=1 and no hazards -> irq_tag=1 exactly 2 cycles later (IRQ_SYNC=2) for 1 cycle; in_isr=1 from the following cycle.
- Irq deferral and masking:
  - irq asserted while id_jump=1 for 3 cycles -> irq_tag held 0, asserted in the first cycle after id_jump falls.
  - Irq held during ISR -> no second irq_tag until id_eret returns the state to RUN.
- Async reset: reset pulled low mid-ISR, between clock edges -> in_isr=0 and mem_branch_en=0 immediately; after release, behaviour matches RUN.
